// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and coordinate type.
// Renderers import this for screen bounds as well.
package vga_timing_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int CLK_DIV   = 4;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
endpackage

// File: rtl/vga_sync_if.sv
// Raster timing bundle: generator drives it, renderers and the connector consume it.
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  logic   frame_end;
  coord_t x;
  coord_t y;

  modport master (output hsync, vsync, video_on, p_tick, frame_end, x, y);
  modport slave  (input  hsync, vsync, video_on, p_tick, frame_end, x, y);
endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// Free-running board-clock prescaler; p_tick is high one clk in every CLK_DIV.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam int W = $clog2(CLK_DIV);

  logic [W-1:0] cnt_q, cnt_d;

  // CLK_DIV is a power of two, so the natural wrap gives the period.
  always_comb cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign p_tick = (cnt_q == W'(CLK_DIV - 1));
endmodule

// File: rtl/vga_sync.sv
// VGA raster generator: pixel/line counters, registered syncs, visible-area
// flag and a once-per-frame pulse for game logic.
module vga_sync #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);
  import vga_timing_pkg::*;

  localparam coord_t H_END  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_END  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t HS_BEG = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_FIN = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_BEG = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_FIN = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS  = coord_t'(V_DISPLAY);

  logic   p_tick;
  coord_t h_q, h_d, v_q, v_d;
  logic   hsync_q, hsync_d, vsync_q, vsync_d;
  logic   h_last, v_last;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  assign h_last = (h_q == H_END);
  assign v_last = (v_q == V_END);

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (p_tick) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
    end
    // Decoding the next-state values keeps the syncs edge-aligned with x/y.
    hsync_d = !((h_d >= HS_BEG) && (h_d <= HS_FIN));
    vsync_d = !((v_d >= VS_BEG) && (v_d <= VS_FIN));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga.x         = h_q;
  assign vga.y         = v_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.p_tick    = p_tick;
  assign vga.video_on  = (h_q < H_VIS) && (v_q < V_VIS);
  assign vga.frame_end = p_tick && h_last && v_last;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: full horizontal timing with a shortened frame so that
// two frame_end pulses and a mid-frame async reset fit in the run.
module tb_vga_sync;
  import vga_timing_pkg::*;

  // Vertical timing shrunk to 4+1+2+1 = 8 lines; horizontal and CLK_DIV stay nominal.
  localparam int DIV = 4;
  localparam int HT  = 800;
  localparam int HD  = 640;
  localparam int VT  = 8;
  localparam int VD  = 4;
  localparam int HSB = 656, HSE = 751;
  localparam int VSB = 5,   VSE = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_sync_if vif();

  vga_sync #(
    .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(4),   .V_FRONT(1),  .V_SYNC(2),  .V_BACK(1),
    .CLK_DIV(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    bit vo;
    bit hs;
    bit vs;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl[NV];
  int   hits[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: after k clk edges since release, k/DIV pixel ticks have been consumed.
  task automatic check_model(input int k);
    int  n, xm, ym;
    bit  pt, hs, vs, vo, fe;
    n  = k / DIV;
    pt = (k % DIV) == DIV - 1;
    xm = n % HT;
    ym = (n / HT) % VT;
    hs = !(xm >= HSB && xm <= HSE);
    vs = !(ym >= VSB && ym <= VSE);
    vo = (xm < HD) && (ym < VD);
    fe = pt && (xm == HT - 1) && (ym == VT - 1);
    checks++;
    if (vif.x !== coord_t'(xm) || vif.y !== coord_t'(ym) || vif.hsync !== hs ||
        vif.vsync !== vs || vif.video_on !== vo || vif.p_tick !== pt || vif.frame_end !== fe) begin
      errors++;
      $display("FAIL model k=%0d: got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fe=%b expected x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fe=%b",
               k, vif.x, vif.y, vif.hsync, vif.vsync, vif.video_on, vif.p_tick, vif.frame_end,
               xm, ym, hs, vs, vo, pt, fe);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " x"},         32'(vif.x), 0);
    chk({tag, " y"},         32'(vif.y), 0);
    chk({tag, " hsync"},     32'(vif.hsync), 1);
    chk({tag, " vsync"},     32'(vif.vsync), 1);
    chk({tag, " video_on"},  32'(vif.video_on), 1);
    chk({tag, " p_tick"},    32'(vif.p_tick), 0);
    chk({tag, " frame_end"}, 32'(vif.frame_end), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, stop_k, fe_count, fe_prev, first_pt, target_n;

    tbl[0]  = '{0,   0, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{639, 3, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{640, 3, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{0,   4, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{655, 0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{656, 0, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{751, 0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{752, 0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{799, 4, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{0,   5, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{799, 6, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{0,   7, 1'b0, 1'b1, 1'b1};
    foreach (hits[i]) hits[i] = 0;

    reset = 1'b1;
    #23;
    check_reset_state("in reset");

    @(negedge clk);
    reset = 1'b0;
    k = 0;
    fe_count = 0;
    fe_prev  = 0;
    target_n = 2 * HT * VT + 5 * HT + 700;
    stop_k   = target_n * DIV + int'($urandom_range(0, DIV - 1));

    while (k < stop_k && errors < 100) begin
      @(posedge clk);
      k++;
      #1;
      check_model(k);
      if (k % DIV == 1) begin
        for (int i = 0; i < NV; i++) begin
          if (int'(vif.x) == tbl[i].x && int'(vif.y) == tbl[i].y) begin
            hits[i]++;
            chk($sformatf("vec%0d video_on", i), 32'(vif.video_on), 32'(tbl[i].vo));
            chk($sformatf("vec%0d hsync", i),    32'(vif.hsync),    32'(tbl[i].hs));
            chk($sformatf("vec%0d vsync", i),    32'(vif.vsync),    32'(tbl[i].vs));
          end
        end
      end
      if (vif.frame_end === 1'b1) begin
        if (fe_count == 0) chk("first frame_end clk", 32'(k), HT * VT * DIV - 1);
        else               chk("frame_end spacing",   32'(k - fe_prev), HT * VT * DIV);
        fe_prev = k;
        fe_count++;
      end
    end
    chk("frame_end pulses", 32'(fe_count), 2);
    for (int i = 0; i < NV; i++) chk($sformatf("vec%0d reached", i), 32'(hits[i] > 0), 1);

    // Mid-frame async reset while both syncs are active.
    chk("pre-reset x",     32'(vif.x), 700);
    chk("pre-reset y",     32'(vif.y), 5);
    chk("pre-reset hsync", 32'(vif.hsync), 0);
    chk("pre-reset vsync", 32'(vif.vsync), 0);
    #($urandom_range(1, 3));
    reset = 1'b1;
    #1;
    check_reset_state("async reset");
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    check_reset_state("held reset");

    @(negedge clk);
    reset = 1'b0;
    k = 0;
    first_pt = -1;
    while (k < 40 * DIV) begin
      @(posedge clk);
      k++;
      #1;
      check_model(k);
      if (first_pt < 0 && vif.p_tick === 1'b1) first_pt = k;
    end
    chk("first p_tick after release", 32'(first_pt), DIV - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
